// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon tone sequencer: colour codes, FSM states,
// the colour-to-frequency table and the LED one-hot encoding.
package simon_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FREQ_W = 10;

  typedef enum logic [1:0] {
    ColGreen  = 2'd0,
    ColRed    = 2'd1,
    ColYellow = 2'd2,
    ColBlue   = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    StIdle,
    StTone,
    StGap
  } state_e;

  localparam logic [FREQ_W-1:0] FREQ_TABLE [4] = '{10'd415, 10'd310, 10'd252, 10'd209};

  function automatic logic [FREQ_W-1:0] tone_freq(input color_e c);
    return FREQ_TABLE[c];
  endfunction

  function automatic logic [3:0] color_led(input color_e c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_tone_sequencer_ms_tick.sv
// Millisecond tick generator: counts 0..clk_counter-1 and ticks on the wrap cycle.
module ms_tick
  import simon_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_clk_counter,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;

  assign w_limit = (i_clk_counter == '0) ? CNT_W'(1) : i_clk_counter;
  // >= so a mid-count reduction of clk_counter still wraps on the next cycle
  assign o_tick  = (r_cnt >= w_limit - CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/simon_tone_sequencer.sv
// Plays the stored Simon colour sequence (or a single feedback tone) as timed tone/gap
// periods, driving the tone generator frequency and the colour LEDs.
module simon_tone_sequencer
  import simon_pkg::*;
#(
  parameter  int unsigned TONE_MS = 420,
  parameter  int unsigned GAP_MS  = 50,
  parameter  int unsigned DEPTH   = 32,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CNT_W-1:0]  i_clk_counter,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [1:0]        i_wr_color,
  input  logic              i_start,
  input  logic [AW:0]       i_seq_len,
  input  logic              i_tone_req,
  input  logic [1:0]        i_tone_color,
  output logic [FREQ_W-1:0] o_frequency,
  output logic [3:0]        o_led,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_MS - 1);

  color_e            r_mem [DEPTH];
  state_e            r_state;
  logic [AW-1:0]     r_idx;
  logic [AW:0]       r_len;
  logic              r_single;
  logic [CNT_W-1:0]  r_ms;
  logic [FREQ_W-1:0] r_freq;
  logic [3:0]        r_led;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_clear;
  logic              w_last;
  logic [AW-1:0]     w_next_idx;
  color_e            w_next_col;
  color_e            w_first_col;
  color_e            w_req_col;

  assign w_clear     = (r_state == StIdle);
  assign w_last      = ({1'b0, r_idx} == r_len - (AW + 1)'(1));
  assign w_next_idx  = r_idx + AW'(1);
  assign w_next_col  = r_mem[w_next_idx];
  assign w_first_col = r_mem[0];
  assign w_req_col   = color_e'(i_tone_color);

  ms_tick u_ms_tick (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (w_clear),
    .i_clk_counter (i_clk_counter),
    .o_tick        (w_tick)
  );

  // Sequence memory is deliberately not reset; the controller owns its contents.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (r_state == StIdle)) begin
      r_mem[i_wr_addr] <= color_e'(i_wr_color);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_len    <= '0;
      r_single <= 1'b0;
      r_ms     <= '0;
      r_freq   <= '0;
      r_led    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_ms <= '0;
          if (i_start) begin
            if (i_seq_len != '0) begin
              r_len    <= i_seq_len;
              r_idx    <= '0;
              r_single <= 1'b0;
              r_freq   <= tone_freq(w_first_col);
              r_led    <= color_led(w_first_col);
              r_busy   <= 1'b1;
              r_state  <= StTone;
            end else begin
              r_done <= 1'b1;
            end
          end else if (i_tone_req) begin
            r_single <= 1'b1;
            r_freq   <= tone_freq(w_req_col);
            r_led    <= color_led(w_req_col);
            r_busy   <= 1'b1;
            r_state  <= StTone;
          end
        end
        StTone: begin
          if (w_tick) begin
            if (r_ms == TONE_LAST) begin
              r_ms    <= '0;
              r_freq  <= '0;
              r_led   <= '0;
              r_state <= StGap;
            end else begin
              r_ms <= r_ms + CNT_W'(1);
            end
          end
        end
        StGap: begin
          if (w_tick) begin
            if (r_ms == GAP_LAST) begin
              r_ms <= '0;
              if (r_single || w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= StIdle;
              end else begin
                r_idx   <= w_next_idx;
                r_freq  <= tone_freq(w_next_col);
                r_led   <= color_led(w_next_col);
                r_state <= StTone;
              end
            end else begin
              r_ms <= r_ms + CNT_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_frequency = r_freq;
  assign o_led       = r_led;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Self-checking bench: per-cycle expected outputs are queued when a request is driven
// and popped/compared on each falling edge.
module tb_simon_tone_sequencer;

  localparam int unsigned TONE = 3;
  localparam int unsigned GAP  = 1;

  typedef struct packed {
    logic [9:0] freq;
    logic [3:0] led;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    bit          s;
    bit          t;
    logic [5:0]  len;
    logic [1:0]  color;
    logic [15:0] cc;
    string       name;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_clk_counter = 16'd2;
  logic        i_wr_en = 1'b0;
  logic [4:0]  i_wr_addr = '0;
  logic [1:0]  i_wr_color = '0;
  logic        i_start = 1'b0;
  logic [5:0]  i_seq_len = '0;
  logic        i_tone_req = 1'b0;
  logic [1:0]  i_tone_color = '0;
  logic [9:0]  o_frequency;
  logic [3:0]  o_led;
  logic        o_busy;
  logic        o_done;

  obs_t        exp_q[$];
  logic [1:0]  sh_mem [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs [7];

  simon_tone_sequencer #(
    .TONE_MS (TONE),
    .GAP_MS  (GAP),
    .DEPTH   (32)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clk_counter (i_clk_counter),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_color    (i_wr_color),
    .i_start       (i_start),
    .i_seq_len     (i_seq_len),
    .i_tone_req    (i_tone_req),
    .i_tone_color  (i_tone_color),
    .o_frequency   (o_frequency),
    .o_led         (o_led),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [9:0] ref_freq(input logic [1:0] c);
    case (c)
      2'd0:    return 10'd415;
      2'd1:    return 10'd310;
      2'd2:    return 10'd252;
      default: return 10'd209;
    endcase
  endfunction

  task automatic push_n(input obs_t o, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(o);
  endtask

  task automatic push_tone(input logic [1:0] c, input int cce);
    obs_t o;
    o = '{freq: ref_freq(c), led: 4'b0001 << c, busy: 1'b1, done: 1'b0};
    push_n(o, TONE * cce);
    o = '{freq: 10'd0, led: 4'b0000, busy: 1'b1, done: 1'b0};
    push_n(o, GAP * cce);
  endtask

  task automatic expect_play(input bit s, input bit t, input int len, input logic [1:0] c,
                             input logic [15:0] cc);
    int cce;
    cce = (cc == 16'd0) ? 1 : int'(cc);
    if (s) begin
      for (int i = 0; i < len; i++) push_tone(sh_mem[i], cce);
    end else if (t) begin
      push_tone(c, cce);
    end
    push_n('{freq: 10'd0, led: 4'b0, busy: 1'b0, done: 1'b1}, 1);
    push_n('{freq: 10'd0, led: 4'b0, busy: 1'b0, done: 1'b0}, 1);
  endtask

  task automatic cmp(input string tag, input int idx, input obs_t e);
    obs_t a;
    a = '{freq: o_frequency, led: o_led, busy: o_busy, done: o_done};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got freq=%0d led=%b busy=%b done=%b, need freq=%0d led=%b busy=%b done=%b",
               tag, idx, a.freq, a.led, a.busy, a.done, e.freq, e.led, e.busy, e.done);
    end
  endtask

  task automatic check_n(input string tag, input int n, inout int idx);
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge i_clk);
      cmp(tag, idx, exp_q.pop_front());
      idx++;
    end
  endtask

  task automatic drain(input string tag, inout int idx);
    check_n(tag, exp_q.size(), idx);
  endtask

  task automatic write_mem(input int a, input logic [1:0] c);
    i_wr_en = 1'b1; i_wr_addr = 5'(a); i_wr_color = c;
    sh_mem[a] = c;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit t, input logic [5:0] len, input logic [1:0] c);
    i_start = s; i_tone_req = t; i_seq_len = len; i_tone_color = c;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_tone_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int idx;
    idx = 0;
    i_clk_counter = v.cc;
    expect_play(v.s, v.t, int'(v.len), v.color, v.cc);
    pulse(v.s, v.t, v.len, v.color);
    drain(v.name, idx);
  endtask

  initial begin
    int idx;
    vecs[0] = '{s: 1, t: 0, len: 6'd3, color: 2'd0, cc: 16'd2, name: "seq3"};
    vecs[1] = '{s: 1, t: 0, len: 6'd0, color: 2'd0, cc: 16'd2, name: "len0"};
    vecs[2] = '{s: 0, t: 1, len: 6'd0, color: 2'd2, cc: 16'd2, name: "tone_yellow"};
    vecs[3] = '{s: 1, t: 1, len: 6'd1, color: 2'd3, cc: 16'd2, name: "start_wins"};
    vecs[4] = '{s: 1, t: 0, len: 6'd2, color: 2'd0, cc: 16'd3, name: "cc3_len2"};
    vecs[5] = '{s: 1, t: 0, len: 6'd1, color: 2'd0, cc: 16'd0, name: "cc0_len1"};
    vecs[6] = '{s: 0, t: 1, len: 6'd0, color: 2'd1, cc: 16'd1, name: "tone_red_cc1"};

    #12;
    cmp("reset", 0, '{freq: 10'd0, led: 4'b0, busy: 1'b0, done: 1'b0});
    i_rst_n = 1'b1;
    write_mem(0, 2'd0);
    write_mem(1, 2'd3);
    write_mem(2, 2'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start arriving mid-tone must be ignored
    idx = 0;
    i_clk_counter = 16'd2;
    expect_play(1'b0, 1'b1, 0, 2'd2, 16'd2);
    pulse(1'b0, 1'b1, 6'd0, 2'd2);
    check_n("mid_start", 2, idx);
    pulse(1'b1, 1'b0, 6'd3, 2'd0);
    drain("mid_start", idx);

    // write while busy is dropped; replay shows the old contents
    idx = 0;
    expect_play(1'b1, 1'b0, 3, 2'd0, 16'd2);
    pulse(1'b1, 1'b0, 6'd3, 2'd0);
    check_n("busy_write", 3, idx);
    i_wr_en = 1'b1; i_wr_addr = 5'd0; i_wr_color = 2'd2;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
    drain("busy_write", idx);
    run_vec('{s: 1, t: 0, len: 6'd3, color: 2'd0, cc: 16'd2, name: "replay"});

    // async reset in the third tone (310 Hz)
    idx = 0;
    expect_play(1'b1, 1'b0, 3, 2'd0, 16'd2);
    pulse(1'b1, 1'b0, 6'd3, 2'd0);
    check_n("pre_rst", 18, idx);
    #2 i_rst_n = 1'b0;
    #1 cmp("async_rst", 0, '{freq: 10'd0, led: 4'b0, busy: 1'b0, done: 1'b0});
    exp_q.delete();
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    cmp("post_rst", 0, '{freq: 10'd0, led: 4'b0, busy: 1'b0, done: 1'b0});
    run_vec('{s: 1, t: 0, len: 6'd3, color: 2'd0, cc: 16'd2, name: "after_rst"});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
